best_arr_readout_sched: RTL
===========================

// Module: best_arr_readout_sched
// PURPOSE
//  Sequences readback of the best-match index array after the main algorithm finishes (send_best_arr phase).
//  Walks the array in blocked order (half px, x-block, row y, column-in-block xi) and issues reads to the 1-cycle-latency index RAM.
//  Pushes each returned index into the output FIFO write port, honouring FIFO backpressure.
//  Sits between the top-level control FSM and the output async FIFO.
// PARAMETERS
//  DATA_WIDTH  11                       output FIFO word width
//  IDX_WIDTH   9                        stored index width; IDX_WIDTH <= DATA_WIDTH-2
//  ROW_SIZE    26                       patches per row; must be even; HALF = ROW_SIZE/2
//  COL_SIZE    19                       rows
//  BLOCKING    4                        columns per x-block; NXB = ceil(HALF/BLOCKING); last block width LBW = HALF-(NXB-1)*BLOCKING
//  NUM_QUERYS  ROW_SIZE*COL_SIZE        array depth
//  QADDRW      $clog2(NUM_QUERYS)       RAM address width
// PORTS
//  clk          in   1            single clock
//  rst          in   1            asynchronous, active-high reset
//  start        in   1            1-cycle pulse; begins readback when idle
//  busy         out  1            high from the cycle after start is accepted until done
//  done         out  1            1-cycle pulse after the last word is enqueued
//  mem_rd_en    out  1            RAM read strobe
//  mem_rd_addr  out  QADDRW       RAM read address
//  mem_rd_data  in   IDX_WIDTH    RAM data, valid the cycle after mem_rd_en
//  fifo_wenq    out  1            FIFO write; a word transfers when fifo_wenq && fifo_wfull_n
//  fifo_wdata   out  DATA_WIDTH   FIFO write data
//  fifo_wfull_n in   1            FIFO not-full
// BEHAVIOUR
//  Reset: state IDLE, all counters 0, buffer empty; busy=done=mem_rd_en=fifo_wenq=0; mem_rd_addr=0; fifo_wdata=0.
//  FSM states:
//   - IDLE -> RUN on start.
//   - RUN -> DRAIN after the last read issues.
//   - DRAIN -> IDLE when the buffer is empty and nothing is in flight; done pulses in the first IDLE cycle.
//   - start outside IDLE is ignored.
//  Address order:
//   - Nested loops, outermost first: px 0..1, x 0..NXB-1, y 0..COL_SIZE-1, xi 0..BLOCKING-1.
//   - (x==NXB-1 && xi>=LBW) is skipped with no idle cycle.
//   - addr = px*HALF + y*ROW_SIZE + x*BLOCKING + xi. Computed incrementally; no multipliers.
//  Buffering:
//   - 2-entry output buffer.
//   - Issue mem_rd_en only if (buffer count + in-flight read - pop this cycle) < 2, so no returned word is ever dropped.
//   - Returned data is written into the buffer at the edge after the read.
//   - fifo_wenq = buffer non-empty; fifo_wdata = head entry, registered.
//  Throughput and latency:
//   - Throughput is 1 word/cycle while fifo_wfull_n=1.
//   - start at edge e0 -> first mem_rd_en in cycle 1 -> first fifo_wenq in cycle 3.
//  Data: fifo_wdata[IDX_WIDTH-1:0] = index. Upper bits follow CONFIGURATION.
//  Backpressure: while fifo_wfull_n=0, fifo_wenq holds and data is stable; reads stall once the buffer plus in-flight reach 2.
//  Total words = 2*HALF*COL_SIZE = NUM_QUERYS. Each address is emitted exactly once.
//  Reset mid-operation: abort immediately, no done pulse, state returns to IDLE. A stale RAM return is discarded.
// CONFIGURATION
//  OUT_TAG_EN defined:
//   - fifo_wdata[DATA_WIDTH-1] = 1 on the first word of each px half.
//   - fifo_wdata[DATA_WIDTH-2] = 1 on the final word.
//  OUT_TAG_EN undefined: bits above IDX_WIDTH-1 are 0.
// TESTING
//  1. Reset, start, fifo_wfull_n=1 -> 494 words.
//     - Addresses 0,1,2,3,26,27,28,29,... and addr 12 is followed by 38.
//     - The px=1 half begins at 13; the last address is 493.
//     - done pulses exactly once, about 497 cycles after start.
//  2. Hold fifo_wfull_n=0 for 20 cycles mid-run -> at most 2 reads outstanding; no word lost or duplicated; sequence identical to scenario 1.
//  3. Toggle fifo_wfull_n at random (50%) -> enqueued stream equals the scenario 1 sequence.
//  4. Pulse start again while busy -> ignored; still exactly 494 words and one done.
//  5. Assert rst at word 100 -> all outputs 0 next cycle; no done; a later start replays from addr 0.
//  6. With OUT_TAG_EN -> bit10 set on words 0 and 247; bit9 set on word 493 only.

Source files
------------

// File: rtl/best_arr_readout_sched.sv
// best_arr_readout_sched
// Reads the best-match index array back in blocked order after the main search
// finishes and forwards every index to the output FIFO write port.
// Order: px half, x-block, row y, column-in-block xi. The narrow last x-block is
// walked without idle cycles.
// A 2-entry buffer absorbs the 1-cycle RAM latency. Reads are gated so that
// FIFO backpressure never drops a returned word.
// Optional build macro OUT_TAG_EN: when defined, fifo_wdata[DATA_WIDTH-1] marks
// the first word of each px half and fifo_wdata[DATA_WIDTH-2] marks the final
// word. When undefined, the bits above the index are zero.
module best_arr_readout_sched #(
    parameter int DATA_WIDTH = 11,
    parameter int IDX_WIDTH  = 9,
    parameter int ROW_SIZE   = 26,
    parameter int COL_SIZE   = 19,
    parameter int BLOCKING   = 4,
    parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
    parameter int QADDRW     = $clog2(NUM_QUERYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [QADDRW-1:0]     mem_rd_addr,
    input  logic [IDX_WIDTH-1:0]  mem_rd_data,
    output logic                  fifo_wenq,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    input  logic                  fifo_wfull_n
);
    localparam int HALF = ROW_SIZE / 2;
    localparam int NXB  = (HALF + BLOCKING - 1) / BLOCKING;
    localparam int LBW  = HALF - (NXB - 1) * BLOCKING;
    localparam int XW   = $clog2(NXB + 1);
    localparam int YW   = $clog2(COL_SIZE + 1);
    localparam int IW   = $clog2(BLOCKING + 1);

    localparam logic [XW-1:0]     X_LAST   = XW'(NXB - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(COL_SIZE - 1);
    localparam logic [IW-1:0]     XI_FULL  = IW'(BLOCKING - 1);
    localparam logic [IW-1:0]     XI_SHORT = IW'(LBW - 1);
    localparam logic [QADDRW-1:0] ROW_Q    = QADDRW'(ROW_SIZE);
    localparam logic [QADDRW-1:0] BLK_Q    = QADDRW'(BLOCKING);
    localparam logic [QADDRW-1:0] HALF_Q   = QADDRW'(HALF);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_px;
    logic [XW-1:0]           r_x;
    logic [YW-1:0]           r_y;
    logic [IW-1:0]           r_xi;
    logic [QADDRW-1:0]       r_xbase;
    logic [QADDRW-1:0]       r_rowbase;
    logic                    r_inflight;
    logic [1:0]              r_cnt;
    logic                    r_wp;
    logic                    r_rp;
    logic [DATA_WIDTH-1:0]   r_buf [2];
    logic                    r_done;

    logic                    w_last_col;
    logic                    w_last_row;
    logic                    w_last_x;
    logic                    w_last;
    logic                    w_pop;
    logic [2:0]              w_occ;
    logic                    w_rd_en;
    logic [DATA_WIDTH-1:0]   w_word;

    assign w_last_col = (r_xi == ((r_x == X_LAST) ? XI_SHORT : XI_FULL));
    assign w_last_row = (r_y == Y_LAST);
    assign w_last_x   = (r_x == X_LAST);
    assign w_last     = w_last_col && w_last_row && w_last_x && r_px;
    assign w_pop      = (r_cnt != 2'd0) && fifo_wfull_n;
    // Occupancy after this cycle's pop; a new read is allowed only if its return still fits.
    assign w_occ      = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en    = (r_state == S_RUN) && (w_occ < 3'd2);

    assign mem_rd_addr = r_rowbase + QADDRW'(r_xi);
    assign fifo_wenq   = (r_cnt != 2'd0);
    assign fifo_wdata  = r_buf[r_rp];
    assign done        = r_done;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and control outputs
    always_comb begin
        w_next    = r_state;
        busy      = (r_state != S_IDLE);
        mem_rd_en = w_rd_en;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_rd_en && w_last) w_next = S_DRAIN;
            S_DRAIN: if (r_cnt == 2'd0 && !r_inflight) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Done pulse in the first IDLE cycle after draining
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_done <= 1'b0;
        else     r_done <= (r_state == S_DRAIN) && (w_next == S_IDLE);
    end

    // Blocked-order address walk; row base tracks px*HALF + x*BLOCKING + y*ROW_SIZE by addition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_px      <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_xi      <= '0;
            r_xbase   <= '0;
            r_rowbase <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_px      <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_xi      <= '0;
            r_xbase   <= '0;
            r_rowbase <= '0;
        end else if (w_rd_en) begin
            if (!w_last_col) begin
                r_xi <= r_xi + 1'b1;
            end else begin
                r_xi <= '0;
                if (!w_last_row) begin
                    r_y       <= r_y + 1'b1;
                    r_rowbase <= r_rowbase + ROW_Q;
                end else begin
                    r_y <= '0;
                    if (!w_last_x) begin
                        r_x       <= r_x + 1'b1;
                        r_xbase   <= r_xbase + BLK_Q;
                        r_rowbase <= r_xbase + BLK_Q;
                    end else begin
                        r_x <= '0;
                        if (!r_px) begin
                            r_px      <= 1'b1;
                            r_xbase   <= HALF_Q;
                            r_rowbase <= HALF_Q;
                        end else begin
                            r_px      <= 1'b0;
                            r_xbase   <= '0;
                            r_rowbase <= '0;
                        end
                    end
                end
            end
        end
    end

`ifdef OUT_TAG_EN
    logic r_if_first;
    logic r_if_last;

    // Tag flags travel alongside the in-flight read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_first <= 1'b0;
            r_if_last  <= 1'b0;
        end else begin
            r_if_first <= w_rd_en && (r_x == '0) && (r_y == '0) && (r_xi == '0);
            r_if_last  <= w_rd_en && w_last;
        end
    end

    // Returned word with tag bits
    always_comb begin
        w_word                  = '0;
        w_word[IDX_WIDTH-1:0]   = mem_rd_data;
        w_word[DATA_WIDTH-1]    = r_if_first;
        w_word[DATA_WIDTH-2]    = r_if_last;
    end
`else
    // Returned word, upper bits zero
    always_comb begin
        w_word = DATA_WIDTH'(mem_rd_data);
    end
`endif

    // 2-entry output buffer; a reset also discards any read still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_cnt      <= 2'd0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) r_buf[i] <= '0;
        end else begin
            r_inflight <= w_rd_en;
            r_cnt      <= w_occ[1:0];
            if (r_inflight) begin
                r_buf[r_wp] <= w_word;
                r_wp        <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
        end
    end
endmodule
